// File: rtl/risc_pkg.sv
// Shared definitions for the multi-cycle RISC core: opcodes, FSM states,
// status bit positions and instruction field positions.
package risc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_LD   = 4'h7;
  localparam logic [3:0] OP_ST   = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_BRZ  = 4'hA;
  localparam logic [3:0] OP_BRN  = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int SB_Z      = 0;
  localparam int SB_N      = 1;
  localparam int SB_C      = 2;
  localparam int SB_BUSERR = 3;
  localparam int SB_ILL    = 4;
  localparam int SB_STATE  = 5;

  localparam int IR_OP = 12;
  localparam int IR_W  = 9;
  localparam int IR_R  = 6;
  localparam int IR_S  = 3;
  localparam int IMM_W = 9;

endpackage

// File: rtl/risc_regfile.sv
// 8-entry register file: two combinational read ports, one synchronous
// write port, cleared by synchronous reset.
module risc_regfile #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [2:0]        wa_i,
  input  logic [DATA_W-1:0] wd_i,
  input  logic [2:0]        ra_i,
  input  logic [2:0]        rb_i,
  output logic [DATA_W-1:0] rd_a_o,
  output logic [DATA_W-1:0] rd_b_o
);

  logic [DATA_W-1:0] regs_q [8];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  assign rd_a_o = regs_q[ra_i];
  assign rd_b_o = regs_q[rb_i];

endmodule

// File: rtl/risc_core_mc.sv
// Multi-cycle RISC core (FETCH/DECODE/EXEC/MEM/HALT) with req/ack memory bus.
// Optional bus timeout abort is enabled by defining RISC_BUS_TIMEOUT_EN.
module risc_core_mc
  import risc_pkg::*;
#(
  parameter int                DATA_W      = 16,
  parameter int                ADDR_W      = 16,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] D_in,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] D_out,
  output logic              mem_req,
  output logic              mw_en,
  output logic              halted,
  output logic [7:0]        status
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [15:0]       ir_q;
  logic [DATA_W-1:0] opa_q, opb_q;
  logic              z_q, n_q, c_q, ill_q;
  logic              abort, bus_err;

  logic [3:0]        op;
  logic [DATA_W-1:0] imm_d, rd_a, rd_b, wr_data;
  logic [ADDR_W-1:0] off_a;
  logic [DATA_W:0]   alu_sum;
  logic              is_alu, wr_en;

  assign op     = ir_q[IR_OP+:4];
  assign imm_d  = {{(DATA_W-IMM_W){ir_q[IMM_W-1]}}, ir_q[IMM_W-1:0]};
  assign off_a  = {{(ADDR_W-IMM_W){ir_q[IMM_W-1]}}, ir_q[IMM_W-1:0]};
  assign is_alu = (op >= OP_ADD) && (op <= OP_XOR);

  risc_regfile #(.DATA_W(DATA_W)) u_rf (
    .clk    (clk),
    .rst    (reset),
    .we_i   (wr_en),
    .wa_i   (ir_q[IR_W+:3]),
    .wd_i   (wr_data),
    .ra_i   (ir_q[IR_R+:3]),
    .rb_i   (ir_q[IR_S+:3]),
    .rd_a_o (rd_a),
    .rd_b_o (rd_b)
  );

  // Carry is bit DATA_W; SUB uses Rr + ~Rs + 1 so C means "no borrow".
  always_comb begin
    alu_sum = '0;
    case (op)
      OP_ADD:  alu_sum = {1'b0, opa_q} + {1'b0, opb_q};
      OP_SUB:  alu_sum = {1'b0, opa_q} + {1'b0, ~opb_q} + {{DATA_W{1'b0}}, 1'b1};
      OP_AND:  alu_sum = {1'b0, opa_q & opb_q};
      OP_OR:   alu_sum = {1'b0, opa_q | opb_q};
      OP_XOR:  alu_sum = {1'b0, opa_q ^ opb_q};
      default: alu_sum = '0;
    endcase
  end

  assign wr_en   = !reset && (((state_q == ST_EXEC) && (is_alu || (op == OP_LDI))) ||
                              ((state_q == ST_MEM) && (op == OP_LD) && mem_ack));
  assign wr_data = (state_q == ST_MEM) ? D_in : ((op == OP_LDI) ? imm_d : alu_sum[DATA_W-1:0]);

`ifdef RISC_BUS_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
  logic [WAIT_W-1:0] wait_q;
  logic              bus_err_q;

  assign abort   = mem_req && !mem_ack && (wait_q == WAIT_W'(TIMEOUT_CYC - 1));
  assign bus_err = bus_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      if (abort) bus_err_q <= 1'b1;
      if (mem_req && !mem_ack && !abort) wait_q <= wait_q + WAIT_W'(1);
      else                               wait_q <= '0;
    end
  end
`else
  assign abort   = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:  if (abort) state_d = ST_HALT; else if (mem_ack) state_d = ST_DECODE;
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        if ((op == OP_LD) || (op == OP_ST)) state_d = ST_MEM;
        else if (op == OP_HALT)             state_d = ST_HALT;
        else                                state_d = ST_FETCH;
      end
      ST_MEM:    if (abort) state_d = ST_HALT; else if (mem_ack) state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    mem_req = 1'b0;
    mw_en   = 1'b0;
    D_out   = '0;
    address = pc_q;
    if (reset) begin
      address = RESET_PC;
    end else begin
      case (state_q)
        ST_FETCH: mem_req = 1'b1;
        ST_MEM: begin
          mem_req = 1'b1;
          address = opa_q[ADDR_W-1:0];
          if (op == OP_ST) begin
            mw_en = 1'b1;
            D_out = opb_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign halted = (state_q == ST_HALT);

  always_comb begin
    status                 = '0;
    status[SB_STATE+:3]    = state_q;
    status[SB_ILL]         = ill_q;
    status[SB_BUSERR]      = bus_err;
    status[SB_C]           = c_q;
    status[SB_N]           = n_q;
    status[SB_Z]           = z_q;
  end

  // Operands are captured in DECODE so EXEC and MEM work from stable copies.
  always_ff @(posedge clk) begin
    if (state_q == ST_DECODE) begin
      opa_q <= rd_a;
      opb_q <= rd_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      ir_q  <= '0;
      z_q   <= 1'b0;
      n_q   <= 1'b0;
      c_q   <= 1'b0;
      ill_q <= 1'b0;
    end else begin
      if ((state_q == ST_FETCH) && mem_ack) begin
        ir_q <= D_in[15:0];
        pc_q <= pc_q + ADDR_W'(1);
      end
      if (state_q == ST_EXEC) begin
        if (is_alu) begin
          z_q <= (alu_sum[DATA_W-1:0] == '0);
          n_q <= alu_sum[DATA_W-1];
        end
        if ((op == OP_ADD) || (op == OP_SUB)) c_q <= alu_sum[DATA_W];
        if (op == OP_JMP)          pc_q <= opa_q[ADDR_W-1:0];
        if ((op == OP_BRZ) && z_q) pc_q <= pc_q + off_a;
        if ((op == OP_BRN) && n_q) pc_q <= pc_q + off_a;
        if ((op >= 4'hC) && (op <= 4'hE)) ill_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_risc_core_mc.sv
// Self-checking bench for risc_core_mc: memory responder with wait states plus
// an instruction-level reference interpreter of the ISA.
module tb_risc_core_mc;

  localparam logic [15:0] RPC = 16'h0100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] D_in = '0;
  logic        mem_ack = 1'b0;
  logic [15:0] address, D_out;
  logic        mem_req, mw_en, halted;
  logic [7:0]  status;

  always #5 clk = ~clk;

  risc_core_mc #(.DATA_W(16), .ADDR_W(16), .RESET_PC(RPC), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .reset(reset), .D_in(D_in), .mem_ack(mem_ack),
    .address(address), .D_out(D_out), .mem_req(mem_req), .mw_en(mw_en),
    .halted(halted), .status(status)
  );

  logic [15:0] mem [65536];
  logic [15:0] mm  [65536];
  int n_pass = 0, n_total = 0, cyc = 0;

  bit ack_en = 0, block_wr = 0, ack_force = 0, wait_rand = 0;
  int wait_cfg = 0, cur_wait = 0, wcnt = 0, t_len = 0, stab_err = 0;
  bit in_txn = 0;
  logic [15:0] t_addr, t_dat;
  logic        t_we;
  logic [15:0] fe_a[$], wr_a[$], wr_d[$], ex_fe[$], ex_wa[$], ex_wd[$], prog[$];
  int          fe_c[$], wr_len[$];
  logic [7:0]  ex_status;

  always @(posedge clk) cyc++;

  // Memory responder: decides ack mid-cycle, logs completed transactions.
  always @(negedge clk) begin
    if (reset || !mem_req) begin
      mem_ack = ack_force;
      in_txn  = 0;
      wcnt    = 0;
    end else begin
      if (!in_txn) begin
        in_txn = 1; wcnt = 0; t_len = 0;
        t_addr = address; t_we = mw_en; t_dat = D_out;
        cur_wait = wait_rand ? int'($urandom_range(0, 2)) : wait_cfg;
      end else if (address !== t_addr || mw_en !== t_we || (t_we && D_out !== t_dat)) begin
        stab_err++;
      end
      t_len++;
      if (ack_en && !(block_wr && mw_en) && wcnt >= cur_wait) begin
        mem_ack = 1'b1;
        D_in    = mem[address];
        if (mw_en) begin
          mem[address] = D_out;
          wr_a.push_back(address); wr_d.push_back(D_out); wr_len.push_back(t_len);
        end else if (status[7:5] == 3'd0) begin
          fe_a.push_back(address); fe_c.push_back(cyc);
        end
        in_txn = 0;
      end else begin
        mem_ack = 1'b0;
        wcnt++;
      end
    end
  end

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] w, input logic [2:0] r, input logic [2:0] s);
    return {op, w, r, s, 3'b000};
  endfunction

  function automatic logic [15:0] enci(input logic [3:0] op, input logic [2:0] w, input logic [8:0] imm);
    return {op, w, imm};
  endfunction

  function automatic logic [15:0] sx(input logic [8:0] v);
    return {{7{v[8]}}, v};
  endfunction

  function automatic int first_diff(input logic [15:0] x[$], input logic [15:0] y[$]);
    if (x.size() != y.size()) return -2;
    foreach (x[i]) if (x[i] !== y[i]) return i;
    return -1;
  endfunction

  // Architectural interpreter: one instruction per step, no notion of cycles.
  task automatic model_run();
    logic [15:0] r[8];
    logic [15:0] pc, ins, a, b, res;
    logic [16:0] wide;
    logic [3:0]  op;
    logic        z, n, c, ill, done;
    for (int i = 0; i < 8; i++) r[i] = '0;
    pc = RPC; z = 0; n = 0; c = 0; ill = 0; done = 0;
    ex_fe.delete(); ex_wa.delete(); ex_wd.delete();
    for (int st = 0; st < 2000 && !done; st++) begin
      ex_fe.push_back(pc);
      ins = mm[pc]; pc = pc + 16'd1; op = ins[15:12];
      a = r[ins[8:6]]; b = r[ins[5:3]]; res = '0;
      case (op)
        4'h1: begin wide = 17'(a) + 17'(b); res = wide[15:0]; c = wide[16]; end
        4'h2: begin res = a - b; c = (a >= b); end
        4'h3: res = a & b;
        4'h4: res = a | b;
        4'h5: res = a ^ b;
        4'h6: r[ins[11:9]] = sx(ins[8:0]);
        4'h7: r[ins[11:9]] = mm[a];
        4'h8: begin mm[a] = b; ex_wa.push_back(a); ex_wd.push_back(b); end
        4'h9: pc = a;
        4'hA: if (z) pc = pc + sx(ins[8:0]);
        4'hB: if (n) pc = pc + sx(ins[8:0]);
        4'hC, 4'hD, 4'hE: ill = 1;
        4'hF: done = 1;
        default: ;
      endcase
      if (op >= 4'h1 && op <= 4'h5) begin
        r[ins[11:9]] = res; z = (res == 16'd0); n = res[15];
      end
    end
    ex_status = {3'd4, ill, 1'b0, c, n, z};
  endtask

  task automatic start_prog();
    @(posedge clk); #1;
    reset = 1; ack_en = 1;
    for (int a = 0; a < 64; a++) begin mem[a] = '0; mm[a] = '0; end
    foreach (prog[i]) begin mem[RPC + 16'(i)] = prog[i]; mm[RPC + 16'(i)] = prog[i]; end
    fe_a.delete(); fe_c.delete(); wr_a.delete(); wr_d.delete(); wr_len.delete();
    stab_err = 0;
    model_run();
    @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic run_prog(input string name);
    int d;
    ack_force = 0; block_wr = 0;
    start_prog();
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      if (halted) break;
    end
    n_total++;
    if (halted !== 1'b1) $display("FAIL %s halt: halted=%b after budget, required 1", name, halted);
    else n_pass++;
    d = first_diff(fe_a, ex_fe);
    n_total++;
    if (d != -1) $display("FAIL %s fetch_seq: actual %0d fetches (diff at %0d), required %0d", name, fe_a.size(), d, ex_fe.size());
    else n_pass++;
    d = first_diff(wr_a, ex_wa);
    n_total++;
    if (d != -1) $display("FAIL %s write_addr: actual %0d writes (diff at %0d), required %0d", name, wr_a.size(), d, ex_wa.size());
    else n_pass++;
    d = first_diff(wr_d, ex_wd);
    n_total++;
    if (d != -1) $display("FAIL %s write_data: actual %0d writes (diff at %0d), required %0d", name, wr_d.size(), d, ex_wd.size());
    else n_pass++;
    n_total++;
    if (status !== ex_status) $display("FAIL %s status: actual %h, required %h", name, status, ex_status);
    else n_pass++;
    n_total++;
    if (stab_err != 0) $display("FAIL %s bus_stable: actual %0d changes during wait, required 0", name, stab_err);
    else n_pass++;
  endtask

  task automatic test_reset();
    ack_en = 0; reset = 1;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if (mem_req !== 0 || mw_en !== 0 || D_out !== 16'd0)
      $display("FAIL reset_outputs: req=%b mw_en=%b D_out=%h, required 0 0 0000", mem_req, mw_en, D_out);
    else n_pass++;
    n_total++;
    if (address !== RPC) $display("FAIL reset_address: actual %h, required %h", address, RPC);
    else n_pass++;
    n_total++;
    if (status !== 8'h00 || halted !== 0) $display("FAIL reset_status: status=%h halted=%b, required 00 0", status, halted);
    else n_pass++;
    reset = 0; #1;
    n_total++;
    if (mem_req !== 1 || address !== RPC) $display("FAIL reset_first_fetch: req=%b addr=%h, required 1 %h", mem_req, address, RPC);
    else n_pass++;
  endtask

  task automatic test_alu_timing();
    wait_rand = 0; wait_cfg = 0;
    prog = '{enci(4'h6, 3'd1, 9'd5), enci(4'h6, 3'd2, 9'd3), enc(4'h1, 3'd3, 3'd1, 3'd2),
             enc(4'h8, 3'd0, 3'd1, 3'd3), 16'hF000};
    run_prog("alu");
    n_total++;
    if (fe_c.size() < 3) $display("FAIL alu_timing: actual %0d fetches, required >=3", fe_c.size());
    else if (fe_c[2] - fe_c[0] != 6) $display("FAIL alu_timing: actual %0d cycles, required 6", fe_c[2] - fe_c[0]);
    else n_pass++;
    n_total++;
    if (wr_d.size() != 1 || wr_d[0] !== 16'd8) $display("FAIL alu_add_result: writes=%0d, required one write of 0008", wr_d.size());
    else n_pass++;
    n_total++;
    if (status !== 8'h80) $display("FAIL alu_flags: actual %h, required 80", status);
    else n_pass++;
  endtask

  task automatic test_branch();
    wait_rand = 0; wait_cfg = 0;
    prog = '{enci(4'h6, 3'd1, 9'd5), enc(4'h2, 3'd4, 3'd1, 3'd1), enci(4'hA, 3'd0, 9'd2),
             enci(4'h6, 3'd6, 9'd1), enci(4'h6, 3'd6, 9'd2), enci(4'hB, 3'd0, 9'd1),
             enc(4'h8, 3'd0, 3'd1, 3'd4), 16'hF000};
    run_prog("branch");
    n_total++;
    if (fe_a.size() != 6) $display("FAIL branch_skip: actual %0d fetches, required 6", fe_a.size());
    else n_pass++;
    n_total++;
    if (status !== 8'h85) $display("FAIL branch_flags: actual %h, required 85", status);
    else n_pass++;
  endtask

  task automatic test_mem_wait();
    wait_rand = 0; wait_cfg = 3;
    prog = '{enci(4'h6, 3'd1, 9'd5), enci(4'h6, 3'd2, 9'd3), enc(4'h8, 3'd0, 3'd1, 3'd2),
             enc(4'h7, 3'd5, 3'd1, 3'd0), enc(4'h8, 3'd0, 3'd2, 3'd5), 16'hF000};
    run_prog("memwait");
    n_total++;
    if (wr_len.size() < 1 || wr_len[0] != 4) $display("FAIL st_hold: actual %0d cycles, required 4", wr_len.size() ? wr_len[0] : -1);
    else n_pass++;
    n_total++;
    if (wr_a.size() != 2 || wr_a[0] !== 16'd5 || wr_d[0] !== 16'd3 || wr_a[1] !== 16'd3 || wr_d[1] !== 16'd3)
      $display("FAIL ld_st_values: actual %0d writes, required (0005,0003) then (0003,0003)", wr_a.size());
    else n_pass++;
    wait_cfg = 0;
  endtask

  task automatic test_illegal_halt();
    int bad = 0;
    wait_rand = 0; wait_cfg = 0;
    prog = '{16'hD000, 16'hF000};
    run_prog("illegal");
    n_total++;
    if (status !== 8'h90) $display("FAIL illegal_status: actual %h, required 90", status);
    else n_pass++;
    repeat (20) begin
      @(posedge clk); #2;
      if (mem_req !== 0 || halted !== 1) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL halt_quiet: actual %0d active cycles, required 0", bad);
    else n_pass++;
    @(posedge clk); #1 reset = 1; ack_en = 0;
    @(posedge clk); #1 reset = 0; #1;
    n_total++;
    if (status !== 8'h00 || mem_req !== 1 || address !== RPC)
      $display("FAIL halt_reset: status=%h req=%b addr=%h, required 00 1 %h", status, mem_req, address, RPC);
    else n_pass++;
  endtask

  task automatic test_reset_mid_store();
    bit found = 0;
    wait_rand = 0; wait_cfg = 0; ack_force = 0; block_wr = 1;
    prog = '{enci(4'h6, 3'd1, 9'd5), enci(4'h6, 3'd2, 9'd3), enc(4'h8, 3'd0, 3'd1, 3'd2), 16'hF000};
    start_prog();
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #2;
      if (status[7:5] == 3'd3) begin found = 1; break; end
    end
    repeat (2) @(posedge clk);
    #2;
    n_total++;
    if (!found || mw_en !== 1 || address !== 16'd5 || D_out !== 16'd3)
      $display("FAIL st_pending: found=%b mw_en=%b addr=%h D_out=%h, required 1 1 0005 0003", found, mw_en, address, D_out);
    else n_pass++;
    @(posedge clk); #1 reset = 1; ack_force = 1; #1;
    n_total++;
    if (mem_req !== 0 || mw_en !== 0 || D_out !== 16'd0)
      $display("FAIL reset_abandon: req=%b mw_en=%b D_out=%h, required 0 0 0000", mem_req, mw_en, D_out);
    else n_pass++;
    @(posedge clk); #2;
    n_total++;
    if (wr_a.size() != 0) $display("FAIL reset_no_write: actual %0d writes, required 0", wr_a.size());
    else n_pass++;
    prog = '{enc(4'h8, 3'd0, 3'd1, 3'd2), enc(4'h1, 3'd3, 3'd1, 3'd2), 16'hF000};
    run_prog("post_reset");
    n_total++;
    if (wr_a.size() != 1 || wr_a[0] !== 16'd0 || wr_d[0] !== 16'd0 || status !== 8'h81)
      $display("FAIL regs_cleared: writes=%0d status=%h, required one (0000,0000) and 81", wr_a.size(), status);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [3:0] op;
    int sel;
    wait_rand = 1;
    for (int k = 0; k < 4; k++) begin
      prog.delete();
      for (int r = 0; r < 8; r++) prog.push_back(enci(4'h6, 3'(r), 9'($urandom_range(0, 511))));
      for (int i = 0; i < 12; i++) begin
        sel = $urandom_range(0, 9);
        if (sel < 8) begin
          op = 4'(1 + sel % 5);
          prog.push_back(enc(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))));
        end else begin
          op = (sel == 8) ? 4'hA : 4'hB;
          prog.push_back(enci(op, 3'd0, 9'($urandom_range(0, 2))));
        end
      end
      repeat (3) prog.push_back(16'h0000);
      prog.push_back(enci(4'h6, 3'd0, 9'h020));
      for (int r = 1; r < 8; r++) prog.push_back(enc(4'h8, 3'd0, 3'd0, 3'(r)));
      prog.push_back(enc(4'h7, 3'd1, 3'd0, 3'd0));
      prog.push_back(enc(4'h1, 3'd2, 3'd1, 3'd1));
      prog.push_back(enc(4'h8, 3'd0, 3'd0, 3'd2));
      prog.push_back(16'hF000);
      run_prog($sformatf("random%0d", k));
    end
    wait_rand = 0;
  endtask

  task automatic test_timeout();
    int n = 0, bad = 0;
    ack_force = 0; block_wr = 0;
    @(posedge clk); #1 reset = 1; ack_en = 0;
    @(posedge clk); #1 reset = 0; #1;
`ifdef RISC_BUS_TIMEOUT_EN
    for (int i = 0; i < 50; i++) begin
      if (halted) break;
      if (mem_req) n++;
      @(posedge clk); #2;
    end
    n_total++;
    if (halted !== 1 || n != 4) $display("FAIL timeout_halt: halted=%b req_cycles=%0d, required 1 4", halted, n);
    else n_pass++;
    n_total++;
    if (status !== 8'h88) $display("FAIL timeout_status: actual %h, required 88", status);
    else n_pass++;
    ack_force = 1;
    repeat (10) begin
      @(posedge clk); #2;
      if (status !== 8'h88 || mem_req !== 0) bad++;
    end
    ack_force = 0;
    n_total++;
    if (bad != 0) $display("FAIL late_ack: actual %0d disturbed cycles, required 0", bad);
    else n_pass++;
`else
    repeat (100) begin
      @(posedge clk); #2;
      if (status !== 8'h00 || mem_req !== 1 || address !== RPC) bad++;
      n++;
    end
    n_total++;
    if (bad != 0) $display("FAIL no_timeout: actual %0d cycles off FETCH out of %0d, required 0", bad, n);
    else n_pass++;
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 65536; a++) begin mem[a] = '0; mm[a] = '0; end
    test_reset();
    test_alu_timing();
    test_branch();
    test_mem_wait();
    test_illegal_halt();
    test_reset_mid_store();
    test_random();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
